aes_block_assembler: RTL and testbench
======================================

// Module: aes_block_assembler
// PURPOSE
//   Collects the AES plaintext/key stream as WORD_W-bit words over a valid/ready handshake.
//   Packs the words into one 128-bit block, first word in the MSBs.
//   Presents the block on a registered valid/ready output to the 128-bit -> 4x4 state-matrix
//   conversion stage that sits directly downstream.
//   Packing order places word 0 in bits [127:128-WORD_W]. For WORD_W=32, word k is column k of the state.
// PARAMETERS
//   WORD_W   32   input word width; legal values 8, 16, 32, 64. NWORDS = 128/WORD_W.
//   CNT_W    $clog2(NWORDS)+1   width of o_word_count; derived, do not override.
// PORTS
//   i_clk           in   1       clock, all logic on rising edge
//   i_rst           in   1       synchronous reset, active-high
//   i_word_valid    in   1       upstream word valid
//   i_word          in   WORD_W  upstream word data
//   i_word_last     in   1       marks final word of a (possibly short) block
//   o_word_ready    out  1       block can accept a word this cycle
//   o_block_valid   out  1       o_block holds a complete block
//   o_block         out  128     assembled block, MSB = first byte received
//   o_block_short   out  1       block was closed early by i_word_last; tail zero-padded
//   i_block_ready   in   1       downstream accepts the block
//   o_word_count    out  CNT_W   words accepted into the current block (0..NWORDS)
// BEHAVIOUR
//   - Reset (sync, i_rst=1 at a clock edge):
//     - state=FILL; count=0; shift register=0.
//     - o_block_valid=0, o_block_short=0, o_word_count=0.
//     - o_word_ready=1 from the first cycle after reset.
//     - Reset mid-fill or mid-hold discards any partial or held block.
//   - Word accept = i_word_valid & o_word_ready. Block accept = o_block_valid & i_block_ready.
//   - State FILL:
//     - o_word_ready=1, o_block_valid=0.
//     - On each word accept, word k (k = count) is written to bits [127-k*WORD_W -: WORD_W].
//     - count increments on each word accept.
//     - If the accepted word is k = NWORDS-1, or i_word_last=1:
//       - go to HOLD; o_block_valid=1 on the next cycle (1-cycle latency from the final word).
//       - count stays at its final value.
//     - Early close (i_word_last at k < NWORDS-1):
//       - o_block_short=1; bits below word k are forced to 0.
//       - Stale data from the previous block must not leak into the padding.
//     - i_word_last on word NWORDS-1 gives a normal block with o_block_short=0.
//     - i_word_last with i_word_valid=0 is ignored.
//   - State HOLD:
//     - o_word_ready=0. o_block, o_block_short and o_block_valid are held stable until block accept.
//     - On block accept: next cycle state=FILL, o_block_valid=0, count=0, o_block_short=0.
//     - Stored data may be cleared or left in place; it is invisible while o_block_valid=0.
//   - Ordering: no word is accepted in the same cycle as a block accept. Steady-state throughput
//     is one block per NWORDS+1 cycles when both sides stream continuously.
//   - Data-hold rules:
//     - i_word is ignored when no word accept occurs.
//     - o_block must not change while o_block_valid=1 and i_block_ready=0.
//   - o_word_ready and o_block_valid are driven from registered state only. There is no
//     combinational path from i_block_ready or i_word_valid to any output.
//   - o_word_count = words accepted into the current block. It saturates at NWORDS in HOLD for a
//     full block and holds k+1 in HOLD for a short block.
// TESTING
//   1. WORD_W=32:
//      - Stimulus: stream 00112233, 44556677, 8899aabb, ccddeeff with valid=1 and i_block_ready=1.
//      - Response: cycle after the 4th accept, o_block_valid=1 and
//        o_block=00112233445566778899aabbccddeeff, o_block_short=0.
//      - Then o_word_ready=1 one cycle after the block accept.
//   2. Backpressure:
//      - Stimulus: full block, i_block_ready=0 for 6 cycles, then 1.
//      - Response: o_block stable and o_word_ready=0 for all 6 cycles; a single block accept;
//        o_word_count returns to 0.
//   3. Short block:
//      - Stimulus: after a full all-ones block, send words deadbeef, 01234567 with i_word_last
//        on the 2nd word.
//      - Response: o_block=deadbeef012345670000000000000000, o_block_short=1, o_word_count=2.
//   4. Reset mid-fill:
//      - Stimulus: 2 words accepted, i_rst=1 for one cycle, then the 4 words of test 1.
//      - Response: o_block_valid=0 in the cycle after reset; next block exactly as in test 1.
//   5. Continuous streaming:
//      - Stimulus: i_word_valid=1, i_block_ready=1 for 30 cycles with an incrementing word.
//      - Response: o_block_valid pulses every 5 cycles; no word is lost or duplicated.
//   6. WORD_W=8:
//      - Stimulus: bytes 00..0f.
//      - Response: o_block=000102030405060708090a0b0c0d0e0f; o_block_valid=1 exactly one cycle
//        after the 16th byte accept.

Source files
------------

// File: rtl/aes_block_assembler.sv
// Packs WORD_W-bit words (first word in the MSBs) into a 128-bit block; block is valid the cycle after its final word.
// Upstream is stalled (o_word_ready=0) while a block is held; o_block stays frozen until i_block_ready.
module aes_block_assembler #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(128 / WORD_W) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_word_valid,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_word_last,
  output logic              o_word_ready,
  output logic              o_block_valid,
  output logic [127:0]      o_block,
  output logic              o_block_short,
  input  logic              i_block_ready,
  output logic [CNT_W-1:0]  o_word_count
);

  localparam int NWORDS = 128 / WORD_W;

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] wordCount;
  logic [CNT_W-2:0] slot;
  logic [127:0]     blockReg;
  logic [127:0]     blockBase;
  logic [127:0]     blockNext;
  logic             shortReg;
  logic             wordAccept;
  logic             blockAccept;
  logic             finalWord;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FILL;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState   = state;
    wordAccept  = 1'b0;
    blockAccept = 1'b0;
    finalWord   = 1'b0;
    unique case (state)
      FILL: begin
        wordAccept = i_word_valid;
        finalWord  = (wordCount == CNT_W'(NWORDS - 1)) || i_word_last;
        if (wordAccept && finalWord) begin
          nextState = HOLD;
        end
      end
      HOLD: begin
        blockAccept = i_block_ready;
        if (blockAccept) begin
          nextState = FILL;
        end
      end
      default: nextState = FILL;
    endcase
  end

  // Clearing the whole block on word 0 keeps an early-closed block's tail zero,
  // so nothing from the previous block can leak into the padding.
  assign slot      = wordCount[CNT_W-2:0];
  assign blockBase = (wordCount == '0) ? '0 : blockReg;
  assign blockNext = blockBase | ({i_word, {(128 - WORD_W){1'b0}}} >> (int'(slot) * WORD_W));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wordCount <= '0;
      blockReg  <= '0;
      shortReg  <= 1'b0;
    end else if (wordAccept) begin
      wordCount <= wordCount + CNT_W'(1);
      blockReg  <= blockNext;
      shortReg  <= i_word_last && (wordCount != CNT_W'(NWORDS - 1));
    end else if (blockAccept) begin
      wordCount <= '0;
      shortReg  <= 1'b0;
    end
  end

  assign o_word_ready  = (state == FILL);
  assign o_block_valid = (state == HOLD);
  assign o_block       = blockReg;
  assign o_block_short = shortReg;
  assign o_word_count  = wordCount;

endmodule

// File: tb/tb_aes_block_assembler.sv
// Self-checking bench for aes_block_assembler: directed scenarios plus a randomized run against a queue-based block model.
module tb_aes_block_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  logic         rst, wVld, wLast, bRdy, wRdy, bVld, bShort;
  logic [31:0]  wDat;
  logic [127:0] blk;
  logic [2:0]   wCnt;

  logic         rst8, wVld8, wLast8, bRdy8, wRdy8, bVld8, bShort8;
  logic [7:0]   wDat8;
  logic [127:0] blk8;
  logic [4:0]   wCnt8;

  typedef struct {
    logic [127:0] data;
    logic         short;
    int           cnt;
  } blk_t;

  aes_block_assembler #(.WORD_W(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_word_valid(wVld), .i_word(wDat), .i_word_last(wLast),
    .o_word_ready(wRdy), .o_block_valid(bVld), .o_block(blk), .o_block_short(bShort),
    .i_block_ready(bRdy), .o_word_count(wCnt)
  );

  aes_block_assembler #(.WORD_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_word_valid(wVld8), .i_word(wDat8), .i_word_last(wLast8),
    .o_word_ready(wRdy8), .o_block_valid(bVld8), .o_block(blk8), .o_block_short(bShort8),
    .i_block_ready(bRdy8), .o_word_count(wCnt8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst = 1'b1; wVld = 1'b0; wLast = 1'b0; bRdy = 1'b0; wDat = '0;
    tick();
    rst = 1'b0;
  endtask

  // Word k lands k*32 bits below the top of the block; unused words stay zero.
  function automatic logic [127:0] pack32(input logic [31:0] ws[4], input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) r = r | ({ws[i], 96'b0} >> (32 * i));
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1; wVld = 1'b1; wDat = $urandom; wLast = 1'b1; bRdy = 1'b0;
    tick();
    rst = 1'b0; wVld = 1'b0; wLast = 1'b0;
    nChecks++; if (wRdy !== 1'b1) begin nFails++; $display("FAIL reset_word_ready: got %b want 1", wRdy); end
    nChecks++; if (bVld !== 1'b0) begin nFails++; $display("FAIL reset_block_valid: got %b want 0", bVld); end
    nChecks++; if (bShort !== 1'b0) begin nFails++; $display("FAIL reset_block_short: got %b want 0", bShort); end
    nChecks++; if (wCnt !== 3'd0) begin nFails++; $display("FAIL reset_word_count: got %0d want 0", wCnt); end
  endtask

  task automatic test_basic;
    logic [31:0] ws[4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    doReset();
    bRdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wVld = 1'b1; wDat = ws[i];
      nChecks++; if (wRdy !== 1'b1) begin nFails++; $display("FAIL basic_ready_w%0d: got %b want 1", i, wRdy); end
      tick();
    end
    wVld = 1'b0;
    nChecks++; if (bVld !== 1'b1) begin nFails++; $display("FAIL basic_valid: got %b want 1", bVld); end
    nChecks++; if (blk !== 128'h00112233445566778899aabbccddeeff) begin nFails++; $display("FAIL basic_block: got %h want 00112233445566778899aabbccddeeff", blk); end
    nChecks++; if (bShort !== 1'b0) begin nFails++; $display("FAIL basic_short: got %b want 0", bShort); end
    nChecks++; if (wCnt !== 3'd4) begin nFails++; $display("FAIL basic_count_full: got %0d want 4", wCnt); end
    tick();
    nChecks++; if (wRdy !== 1'b1 || bVld !== 1'b0) begin nFails++; $display("FAIL basic_after_accept: got rdy=%b vld=%b want rdy=1 vld=0", wRdy, bVld); end
    nChecks++; if (wCnt !== 3'd0) begin nFails++; $display("FAIL basic_count_clear: got %0d want 0", wCnt); end
  endtask

  task automatic test_backpressure;
    logic [31:0]  ws[4];
    logic [127:0] exp;
    doReset();
    for (int i = 0; i < 4; i++) ws[i] = $urandom;
    exp = pack32(ws, 4);
    for (int i = 0; i < 4; i++) begin
      wVld = 1'b1; wDat = ws[i];
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      wDat = $urandom; wLast = 1'($urandom_range(0, 1));
      nChecks++; if (bVld !== 1'b1 || wRdy !== 1'b0) begin nFails++; $display("FAIL bp_hold_c%0d: got vld=%b rdy=%b want vld=1 rdy=0", c, bVld, wRdy); end
      nChecks++; if (blk !== exp) begin nFails++; $display("FAIL bp_stable_c%0d: got %h want %h", c, blk, exp); end
      tick();
    end
    wVld = 1'b0; wLast = 1'b0; bRdy = 1'b1;
    tick();
    nChecks++; if (bVld !== 1'b0 || wCnt !== 3'd0 || wRdy !== 1'b1) begin nFails++; $display("FAIL bp_release: got vld=%b cnt=%0d rdy=%b want vld=0 cnt=0 rdy=1", bVld, wCnt, wRdy); end
  endtask

  task automatic test_short;
    doReset();
    bRdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wVld = 1'b1; wDat = 32'hffffffff;
      tick();
    end
    wVld = 1'b0;
    tick();
    bRdy = 1'b0;
    wVld = 1'b1; wDat = 32'hdeadbeef; wLast = 1'b0;
    tick();
    wDat = 32'h01234567; wLast = 1'b1;
    tick();
    wVld = 1'b0; wLast = 1'b0;
    nChecks++; if (bVld !== 1'b1) begin nFails++; $display("FAIL short_valid: got %b want 1", bVld); end
    nChecks++; if (blk !== 128'hdeadbeef012345670000000000000000) begin nFails++; $display("FAIL short_block: got %h want deadbeef012345670000000000000000", blk); end
    nChecks++; if (bShort !== 1'b1) begin nFails++; $display("FAIL short_flag: got %b want 1", bShort); end
    nChecks++; if (wCnt !== 3'd2) begin nFails++; $display("FAIL short_count: got %0d want 2", wCnt); end
    bRdy = 1'b1;
    tick();
    nChecks++; if (bShort !== 1'b0 || bVld !== 1'b0) begin nFails++; $display("FAIL short_clear: got short=%b vld=%b want 0 0", bShort, bVld); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] ws[4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    doReset();
    bRdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wVld = 1'b1; wDat = $urandom;
      tick();
    end
    wVld = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    nChecks++; if (bVld !== 1'b0 || wCnt !== 3'd0 || wRdy !== 1'b1) begin nFails++; $display("FAIL rstmid_state: got vld=%b cnt=%0d rdy=%b want 0 0 1", bVld, wCnt, wRdy); end
    for (int i = 0; i < 4; i++) begin
      wVld = 1'b1; wDat = ws[i];
      tick();
    end
    wVld = 1'b0;
    nChecks++; if (bVld !== 1'b1 || blk !== 128'h00112233445566778899aabbccddeeff || bShort !== 1'b0) begin
      nFails++; $display("FAIL rstmid_block: got vld=%b %h short=%b want 1 00112233445566778899aabbccddeeff 0", bVld, blk, bShort);
    end
    tick();
  endtask

  task automatic test_stream;
    logic [31:0] q[$];
    logic [31:0] nextW;
    logic [31:0] ws[4];
    int lastPulse = -1;
    int nBlocks = 0;
    doReset();
    bRdy = 1'b1; wVld = 1'b1;
    nextW = $urandom;
    for (int cyc = 0; cyc < 30; cyc++) begin
      wDat = nextW;
      if (wRdy === 1'b1) begin
        q.push_back(nextW);
        nextW = nextW + 32'd1;
      end
      if (bVld === 1'b1) begin
        if (q.size() < 4) begin
          nChecks++; nFails++; $display("FAIL stream_underflow_c%0d: got %0d queued words want 4", cyc, q.size());
        end else begin
          for (int i = 0; i < 4; i++) ws[i] = q.pop_front();
          nChecks++; if (blk !== pack32(ws, 4)) begin nFails++; $display("FAIL stream_block_c%0d: got %h want %h", cyc, blk, pack32(ws, 4)); end
        end
        if (lastPulse >= 0) begin
          nChecks++; if (cyc - lastPulse != 5) begin nFails++; $display("FAIL stream_period: got %0d want 5", cyc - lastPulse); end
        end
        lastPulse = cyc;
        nBlocks++;
      end
      tick();
    end
    wVld = 1'b0;
    nChecks++; if (nBlocks != 6) begin nFails++; $display("FAIL stream_count: got %0d blocks want 6", nBlocks); end
    nChecks++; if (q.size() != 0) begin nFails++; $display("FAIL stream_leftover: got %0d words want 0", q.size()); end
  endtask

  task automatic test_random;
    blk_t         expQ[$];
    blk_t         e;
    logic [31:0]  cur[4];
    int           n = 0;
    logic         held = 1'b0;
    logic [127:0] prevBlk = '0;
    logic         prevShort = 1'b0;
    doReset();
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (cyc < 300) begin
        wVld  = ($urandom_range(0, 3) != 0);
        wDat  = $urandom;
        wLast = ($urandom_range(0, 4) == 0);
        bRdy  = ($urandom_range(0, 2) != 0);
      end else begin
        wVld = 1'b0; wLast = 1'b0; bRdy = 1'b1;
      end
      nChecks++; if ((wRdy ^ bVld) !== 1'b1) begin nFails++; $display("FAIL rand_exclusive_c%0d: got rdy=%b vld=%b want opposite", cyc, wRdy, bVld); end
      if (held) begin
        nChecks++; if (bVld !== 1'b1 || blk !== prevBlk || bShort !== prevShort) begin
          nFails++; $display("FAIL rand_hold_c%0d: got vld=%b %h short=%b want 1 %h %b", cyc, bVld, blk, bShort, prevBlk, prevShort);
        end
      end
      if (wVld && wRdy === 1'b1) begin
        cur[n] = wDat;
        n++;
        if (wLast || n == 4) begin
          e.data = pack32(cur, n); e.short = (n < 4); e.cnt = n;
          expQ.push_back(e);
          n = 0;
        end
      end
      if (bVld === 1'b1 && bRdy) begin
        if (expQ.size() == 0) begin
          nChecks++; nFails++; $display("FAIL rand_unexpected_c%0d: got block %h want none", cyc, blk);
        end else begin
          e = expQ.pop_front();
          nChecks++; if (blk !== e.data || bShort !== e.short || int'(wCnt) != e.cnt) begin
            nFails++; $display("FAIL rand_block_c%0d: got %h short=%b cnt=%0d want %h short=%b cnt=%0d", cyc, blk, bShort, wCnt, e.data, e.short, e.cnt);
          end
        end
      end
      held = (bVld === 1'b1) && !bRdy;
      prevBlk = blk;
      prevShort = bShort;
      tick();
    end
    nChecks++; if (expQ.size() != 0) begin nFails++; $display("FAIL rand_drain: got %0d pending blocks want 0", expQ.size()); end
  endtask

  task automatic test_byte8;
    logic [127:0] exp = '0;
    rst8 = 1'b1; wVld8 = 1'b0; wLast8 = 1'b0; bRdy8 = 1'b0; wDat8 = '0;
    tick();
    rst8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = (exp << 8) | 128'(i);
      wVld8 = 1'b1; wDat8 = 8'(i);
      tick();
      if (i == 14) begin
        nChecks++; if (bVld8 !== 1'b0) begin nFails++; $display("FAIL byte_early_valid: got %b want 0", bVld8); end
      end
    end
    wVld8 = 1'b0;
    nChecks++; if (bVld8 !== 1'b1) begin nFails++; $display("FAIL byte_valid: got %b want 1", bVld8); end
    nChecks++; if (blk8 !== exp) begin nFails++; $display("FAIL byte_block: got %h want %h", blk8, exp); end
    nChecks++; if (wCnt8 !== 5'd16 || bShort8 !== 1'b0) begin nFails++; $display("FAIL byte_count: got cnt=%0d short=%b want 16 0", wCnt8, bShort8); end
    bRdy8 = 1'b1;
    tick();
    nChecks++; if (bVld8 !== 1'b0 || wRdy8 !== 1'b1) begin nFails++; $display("FAIL byte_release: got vld=%b rdy=%b want 0 1", bVld8, wRdy8); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wVld = 1'b0; wLast = 1'b0; bRdy = 1'b0; wDat = '0;
    rst8 = 1'b1; wVld8 = 1'b0; wLast8 = 1'b0; bRdy8 = 1'b0; wDat8 = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_short();
    test_reset_mid();
    test_stream();
    test_random();
    test_byte8();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
